// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a dual-port SRAM macro: port 0 is write-only, port 1 is
// read-only. Round-robin grant, one transaction in flight, every SRAM-side output is a flop.
module sram_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   // requester 0
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [NUM_WMASKS-1:0] m0_sel,
   input  logic [31:0]           m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   // requester 1
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [NUM_WMASKS-1:0] m1_sel,
   input  logic [31:0]           m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   // SRAM write port
   output logic                  sram_csb0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   // SRAM read port
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_t;

   state_t state;
   logic   grant;       // 0: m0 owns the transaction, 1: m1
   logic   last_grant;
   logic   cur_we;
   logic   cur_oor;

   logic                  pick_m1;
   logic                  req_we;
   logic [NUM_WMASKS-1:0] req_sel;
   logic [31:0]           req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  req_oor;
   logic [ADDR_WIDTH-1:0] req_word;
   logic                  unused_addr_lsbs;

   // Byte offset within a word carries no information for a word-wide SRAM.
   assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

   // Round-robin pick and mux of the winning request fields.
   always_comb begin
      pick_m1   = m1_req & (~m0_req | ~last_grant);
      req_we    = pick_m1 ? m1_we    : m0_we;
      req_sel   = pick_m1 ? m1_sel   : m0_sel;
      req_addr  = pick_m1 ? m1_addr  : m0_addr;
      req_wdata = pick_m1 ? m1_wdata : m0_wdata;
      req_oor   = |req_addr[31:ADDR_WIDTH+2];
      req_word  = req_addr[ADDR_WIDTH+1:2];
   end

   // Transaction FSM; all outputs registered so the SRAM never sees a combinational m* path.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= StIdle;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         cur_we      <= 1'b0;
         cur_oor     <= 1'b0;
         sram_csb0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         sram_csb1   <= 1'b1;
         sram_addr1  <= '0;
         m0_ack      <= 1'b0;
         m1_ack      <= 1'b0;
         m0_rdata    <= '0;
         m1_rdata    <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (m0_req || m1_req) begin
                  grant      <= pick_m1;
                  last_grant <= pick_m1;
                  cur_we     <= req_we;
                  cur_oor    <= req_oor;
                  // An out-of-range request runs the normal schedule with both selects idle.
                  if (req_we) begin
                     sram_csb0   <= req_oor;
                     sram_wmask0 <= req_sel;
                     sram_addr0  <= req_word;
                     sram_din0   <= req_wdata;
                  end else begin
                     sram_csb1  <= req_oor;
                     sram_addr1 <= req_word;
                  end
                  state <= StAccess;
               end
            end
            StAccess: begin
               sram_csb0   <= 1'b1;
               sram_csb1   <= 1'b1;
               sram_wmask0 <= '0;
               if (cur_we) begin
                  m0_ack <= ~grant;
                  m1_ack <= grant;
                  state  <= StResp;
               end else begin
                  state <= StCapture;
               end
            end
            StCapture: begin
               if (grant) begin
                  m1_rdata <= cur_oor ? '0 : sram_dout1;
               end else begin
                  m0_rdata <= cur_oor ? '0 : sram_dout1;
               end
               m0_ack <= ~grant;
               m1_ack <= grant;
               state  <= StResp;
            end
            StResp: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               state  <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural dual-port SRAM, per-master drivers and an
// ack-ordered scoreboard of expected read data.
module tb_sram_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          nrst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [NW-1:0] m0_sel, m1_sel;
   logic [31:0]   m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic          m0_ack, m1_ack;
   logic          sram_csb0, sram_csb1;
   logic [NW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0, sram_addr1;
   logic [DW-1:0] sram_din0, sram_dout1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          m;
      bit          chk;
      logic [31:0] rd;
   } exp_t;
   exp_t sbq[$];

   logic [DW-1:0] mem [0:(1<<AW)-1];

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
      .clk(clk), .nrst(nrst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
      .sram_dout1(sram_dout1)
   );

   always #5 clk = ~clk;

   // SRAM model: selects sampled at the rising edge, read data appears after that edge.
   always @(posedge clk) begin
      if (!sram_csb0) begin
         for (int b = 0; b < NW; b++) begin
            if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
         end
      end
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Invariants and scoreboard pop, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (nrst) begin
         check_eq("dual_select", {31'd0, ~sram_csb0 & ~sram_csb1}, 32'd0);
         check_eq("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
         if (m0_ack || m1_ack) begin
            check_eq("ack_expected", (sbq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               check_eq("ack_master", {31'd0, m1_ack}, e.m);
               if (e.chk) check_eq("rdata", m1_ack ? m1_rdata : m0_rdata, e.rd);
            end
         end
      end
   end

   // Drive one request, hold it until ack; exp_lat = 0 skips latency/access checks.
   task automatic txn(input int m, input logic we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
      int  n;
      bit  got;
      bit  oor;
      logic [AW-1:0] word;
      oor  = |addr[31:AW+2];
      word = addr[AW+1:2];
      @(negedge clk);
      if (m == 0) begin
         m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
      end
      n   = 1;
      got = 1'b0;
      while (n < 30 && !got) begin
         @(negedge clk);
         n++;
         if (exp_lat != 0 && n == 2) begin
            if (oor) begin
               check_eq("oor_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);
            end else if (we) begin
               check_eq("wr_csb0", {31'd0, sram_csb0}, 32'd0);
               check_eq("wr_wmask", {28'd0, sram_wmask0}, {28'd0, sel});
               check_eq("wr_addr0", {21'd0, sram_addr0}, {21'd0, word});
               check_eq("wr_din0", sram_din0, wdata);
            end else begin
               check_eq("rd_csb1", {31'd0, sram_csb1}, 32'd0);
               check_eq("rd_addr1", {21'd0, sram_addr1}, {21'd0, word});
            end
         end
         if (m == 0 ? m0_ack : m1_ack) got = 1'b1;
      end
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
      check_eq("ack_seen", {31'd0, got}, 32'd1);
      if (exp_lat != 0) check_eq("latency", n, exp_lat);
   endtask

   task automatic wr(input int m, input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] data);
      exp_t e;
      e.m = m; e.chk = 1'b0; e.rd = '0;
      sbq.push_back(e);
      txn(m, 1'b1, sel, addr, data, 3);
   endtask

   task automatic rd(input int m, input logic [31:0] addr, input logic [31:0] exp);
      exp_t e;
      e.m = m; e.chk = 1'b1; e.rd = exp;
      sbq.push_back(e);
      txn(m, 1'b0, 4'h0, addr, 32'h0, 4);
   endtask

   task automatic push_rd(input int m, input logic [31:0] exp);
      exp_t e;
      e.m = m; e.chk = 1'b1; e.rd = exp;
      sbq.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      sram_dout1 = '0;
      m0_req = 0; m0_we = 0; m0_sel = '0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_sel = '0; m1_addr = '0; m1_wdata = '0;
      nrst = 1'b1;
      #1 nrst = 1'b0;
      #1;
      check_eq("rst_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);
      check_eq("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      check_eq("rst_m0_rdata", m0_rdata, 32'd0);
      check_eq("rst_wmask", {28'd0, sram_wmask0}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) nrst = 1'b1;

      // Basic write then read-back on m0.
      wr(0, 4'hF, 32'h10, 32'hDEADBEEF);
      rd(0, 32'h10, 32'hDEADBEEF);

      // Partial write merges with the previous word.
      wr(1, 4'hF, 32'h20, 32'h11223344);
      wr(1, 4'b0010, 32'h20, 32'h0000AA00);
      rd(1, 32'h20, 32'h1122AA44);
      check_eq("m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

      // Contended reads alternate, m0 first since m1 was granted last.
      wr(0, 4'hF, 32'h100, 32'hA5A50001);
      wr(1, 4'hF, 32'h104, 32'h5A5A0002);
      push_rd(0, 32'hA5A50001);
      push_rd(1, 32'h5A5A0002);
      push_rd(0, 32'hA5A50001);
      push_rd(1, 32'h5A5A0002);
      fork
         begin
            txn(0, 1'b0, 4'h0, 32'h100, 32'h0, 0);
            txn(0, 1'b0, 4'h0, 32'h100, 32'h0, 0);
         end
         begin
            txn(1, 1'b0, 4'h0, 32'h104, 32'h0, 0);
            txn(1, 1'b0, 4'h0, 32'h104, 32'h0, 0);
         end
      join

      // Out-of-range read returns zero without touching the SRAM.
      rd(0, 32'h0000_8000, 32'h0);

      // Empty byte mask leaves the word intact.
      wr(0, 4'hF, 32'h60, 32'h55555555);
      wr(0, 4'h0, 32'h60, 32'hFFFFFFFF);
      rd(0, 32'h60, 32'h55555555);

      // Reset during the ACCESS cycle of a write aborts it.
      wr(0, 4'hF, 32'h40, 32'h0);
      @(negedge clk);
      m0_we = 1'b1; m0_sel = 4'hF; m0_addr = 32'h40; m0_wdata = 32'hFFFFFFFF; m0_req = 1'b1;
      @(posedge clk);
      #2;
      check_eq("abort_csb0_active", {31'd0, sram_csb0}, 32'd0);
      nrst = 1'b0;
      #1;
      check_eq("abort_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);
      check_eq("abort_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
      check_eq("abort_wmask", {28'd0, sram_wmask0}, 32'd0);
      check_eq("abort_addr0", {21'd0, sram_addr0}, 32'd0);
      check_eq("abort_din0", sram_din0, 32'd0);
      check_eq("abort_m0_rdata", m0_rdata, 32'd0);
      @(negedge clk) m0_req = 1'b0;
      @(negedge clk) nrst = 1'b1;
      rd(0, 32'h40, 32'h0);

      repeat (3) @(negedge clk);
      check_eq("sb_empty", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL be the SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the SRAM word width.
REQ-003 Parameter NUM_WMASKS, default 4, SHALL be the number of byte-write-enable bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: block clock, also the SRAM clk0/clk1.
REQ-006 Port nrst, input, 1: asynchronous active-low reset.
REQ-007 Ports m0_req / m1_req, input, 1: requester n wants an access and holds all request fields until its ack.
REQ-008 Ports m0_we / m1_we, input, 1: 1 means write, 0 means read.
REQ-009 Ports m0_sel / m1_sel, input, NUM_WMASKS: byte enables for a write, ignored for a read.
REQ-010 Ports m0_addr / m1_addr, input, 32: byte address.
REQ-011 Ports m0_wdata / m1_wdata, input, DATA_WIDTH: write data.
REQ-012 Ports m0_ack / m1_ack, output, 1: one-cycle completion pulse.
REQ-013 Ports m0_rdata / m1_rdata, output, DATA_WIDTH: read data, valid while ack is high.
REQ-014 Port sram_csb0, output, 1: active-low write-port select.
REQ-015 Ports sram_wmask0 (NUM_WMASKS), sram_addr0 (ADDR_WIDTH) and sram_din0 (DATA_WIDTH), outputs: write-port fields.
REQ-016 Ports sram_csb1 (1) and sram_addr1 (ADDR_WIDTH), outputs: read-port select and address.
REQ-017 Port sram_dout1, input, DATA_WIDTH: read-port data.

Function
REQ-018 All SRAM-side outputs SHALL come directly from flops, with no combinational path from the m* inputs.
REQ-019 The word address SHALL be addr[ADDR_WIDTH+1:2]; addr[1:0] SHALL be ignored.
REQ-020 A request with any of addr[31:ADDR_WIDTH+2] nonzero SHALL be out of range: no SRAM select is asserted, ack comes on the normal schedule, and rdata is 0.
REQ-021 The FSM SHALL have states IDLE, ACCESS, CAPTURE and RESP.
REQ-022 IDLE: if any req is high at a clock edge, the FSM SHALL grant one requester, latch its fields, drive the SRAM select, address, mask and data, and go to ACCESS.
REQ-023 Arbitration SHALL be round-robin: when both req are high, the requester not granted last wins; a single requester always wins; last_grant SHALL update on every grant.
REQ-024 For a write, ACCESS SHALL assert sram_csb0=0, sram_wmask0=sel, sram_addr0 and sram_din0 for exactly one cycle, then go to RESP.
REQ-025 For a read, ACCESS SHALL assert sram_csb1=0 and sram_addr1 for exactly one cycle, then go to CAPTURE.
REQ-026 CAPTURE SHALL register sram_dout1 into the granted rdata at the next edge, then go to RESP.
REQ-027 RESP SHALL pulse the granted ack for exactly one cycle, then return to IDLE.
REQ-028 A request SHALL NOT be granted in the RESP cycle, so every transaction passes through IDLE.
REQ-029 Latency from first sampled req to ack high SHALL be 3 cycles for a write and 4 cycles for a read, when uncontended.
REQ-030 A write with sel=0 SHALL still be issued with sram_wmask0=0000 and acked normally.
REQ-031 sram_csb0 and sram_csb1 SHALL be high in every state other than ACCESS; the two selects SHALL never be low together.
REQ-032 The rdata of the non-granted requester SHALL hold its last value; acks SHALL never be high together.
REQ-033 A read issued after a write to the same word has been acked SHALL return the written bytes merged with the unwritten bytes.
REQ-034 Dropping req before ack is illegal; the FSM SHALL complete the transaction anyway using the latched fields.

Reset
REQ-035 Asserting nrst low SHALL force, immediately and asynchronously: state IDLE, sram_csb0=1, sram_csb1=1, sram_wmask0=0, addresses and din at 0, acks 0, rdata 0, last_grant=1 so that m0 wins first.
REQ-036 If reset is asserted during ACCESS, the select SHALL already be high at the SRAM sampling edge, so no write SHALL be performed.
REQ-037 No ack SHALL be issued for a transaction cut off by reset.
REQ-038 After nrst rises, the first grant SHALL occur no earlier than the first clock edge.

Verification
REQ-039 Write m0 addr=0x10, sel=1111, wdata=0xDEADBEEF, then read m0 addr=0x10 -> ack at cycles 3 and 4 respectively, rdata=0xDEADBEEF.
REQ-040 Write 0x11223344 to addr 0x20, then write sel=0010, data 0x0000AA00 to addr 0x20, then read addr 0x20 -> rdata=0x1122AA44.
REQ-041 m0 and m1 reads held high together for 4 transactions -> grants alternate m0, m1, m0, m1; no cycle has both acks or both selects low.
REQ-042 Read addr=0x0000_8000 (out of range) -> ack on the normal schedule, rdata=0, sram_csb1 stays high throughout.
REQ-043 nrst pulsed low during the ACCESS state of a write to 0x40 holding 0x0 -> no ack, outputs at reset values, and a later read of 0x40 returns 0x0.
REQ-044 Write with sel=0000 to a word holding 0x55555555 -> ack in 3 cycles, sram_wmask0=0000, and a readback returns 0x55555555.
